aes_word_streamer: RTL and testbench
====================================

# aes_word_streamer

Sequential, parametrised successor to the combinational state unpackers. It registers one SIZE-bit AES block, key or state, through a valid/ready input. It then streams the block out as 32-bit words, one per accepted output handshake, in either column order or row order. It sits between the block/key registers and the word-serial datapaths (key expansion, MixColumns, serial S-box lanes). It supports back-to-back blocks with no bubble and a synchronous flush.

## Interface
- SIZE, 128: block width in bits; legal values 128, 192, 256; any other value is an elaboration error.
- COL_NUM, SIZE/32: derived, not overridable; number of words per block.
- IDX_W, max(1,$clog2(COL_NUM)): derived width of the word index.
- clk  in  1  clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of the block currently held.
- in_valid  in  1  in_data/in_mode are valid.
- in_ready  out  1  block accepted at clk edge when in_valid & in_ready.
- in_data  in  SIZE  block, word i = in_data[32*i +: 32].
- in_mode  in  1  0 = column order, 1 = row order; sampled with the block.
- out_valid  out  1  out_word/out_idx/out_last are valid.
- out_ready  in  1  consumer takes word at clk edge when out_valid & out_ready.
- out_word  out  32  current word.
- out_idx  out  IDX_W  index of current word, 0..COL_NUM-1.
- out_last  out  1  current word is index COL_NUM-1.

## Operation
- FSM has two states. IDLE: out_valid=0. EMIT: out_valid=1.
- IDLE -> EMIT on input handshake: capture in_data into the block register, in_mode into the mode register, and set idx=0.
- EMIT, output handshake, not last: idx+1.
- EMIT, output handshake on last word: with a simultaneous input handshake, reload and set idx=0, staying in EMIT; otherwise go to IDLE.
- in_ready = !flush & (state==IDLE | (out_last & out_ready)). The combinational path out_ready->in_ready is intentional.
- Column word i = block[32*i +: 32].
- Row word r (mode 1, only when COL_NUM==4) = {block[96+8r +: 8], block[64+8r +: 8], block[32+8r +: 8], block[8r +: 8]}.
- When COL_NUM != 4, in_mode is ignored and captured as 0; column order is always used.
- Words are emitted in ascending index; out_last = (idx == COL_NUM-1).
- While out_valid=1 and out_ready=0, out_word/out_idx/out_last hold stable, and the block register and mode register hold stable.
- flush=1: next state IDLE, idx=0. Flush has priority over both handshakes; no word is consumed and no block is accepted in that cycle.
- The block register is not cleared by flush, only invalidated.

## Timing
- Reset (rst_n low, async): state IDLE, idx 0, mode 0, block 0. Outputs: out_valid 0, out_idx 0, out_last 0, out_word 0, in_ready 1 (0 only if flush is high).
- Latency: block accepted at edge N gives word 0 on out_valid from N+1 (registered output, no combinational in->out path).
- Throughput: COL_NUM words per COL_NUM cycles with out_ready held high, including across block boundaries.
- The next block's word 0 appears in the cycle after the previous last word is taken.
- rst_n asserted mid-block discards the block immediately. The first cycle after deassertion is IDLE with in_ready=1.

## Structure
- Shared package aes_stream_pkg holds:
  - localparams WORD_W=32 and BYTE_W=8;
  - typedef enum logic {MODE_COL, MODE_ROW} word_mode_t;
  - typedef enum logic {ST_IDLE, ST_EMIT} stream_state_t;
  - function row_word(block128, r), reused later by the matching packer.
- No sub-module: FSM, counter and the word multiplexer fit one module of roughly 150-200 lines.

## Test plan
- SIZE=128, mode 0, in_data=0x00112233445566778899aabbccddeeff, out_ready=1 -> words 0xccddeeff, 0x8899aabb, 0x44556677, 0x00112233 with idx 0..3, out_last on the 4th word, out_valid high from the cycle after the load.
- Same data, mode 1 -> rows 0x3377bbff, 0x2266aaee, 0x115599dd, 0x004488cc.
- Back-to-back: a second block is presented while the first block's last word is taken -> in_ready=1 in that cycle and 8 contiguous valid words with no bubble. Then toggle out_ready randomly -> words are held stable while stalled and none are lost or duplicated.
- SIZE=256, mode 1 requested, in_data words 0x0..0x7 -> in_mode ignored; 8 column words 0x0..0x7, out_last on idx 7.
- flush asserted at idx 2 with in_valid high -> out_valid 0 the next cycle, the block is not accepted that cycle, and the following load restarts at idx 0.
- rst_n pulsed low mid-stream (asynchronously, between edges) -> out_valid drops immediately, all outputs at reset values, in_ready=1 after release.

Source files
------------

// File: rtl/aes_stream_pkg.sv
// Shared types and helpers for the AES word-serial stream units.
// The row_word helper is meant to be reused by the matching word packer.
package aes_stream_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic {MODE_COL, MODE_ROW} word_mode_t;
  typedef enum logic {ST_IDLE, ST_EMIT} stream_state_t;

  // Row r of a 4x4 AES state: byte r of every column, column 3 in the MSB.
  function automatic logic [WORD_W-1:0] row_word(input logic [127:0] block128,
                                                 input logic [1:0]   r);
    row_word = {block128[96 + BYTE_W*int'(r) +: BYTE_W],
                block128[64 + BYTE_W*int'(r) +: BYTE_W],
                block128[32 + BYTE_W*int'(r) +: BYTE_W],
                block128[     BYTE_W*int'(r) +: BYTE_W]};
  endfunction

endpackage

// File: rtl/aes_word_streamer.sv
// Registers one AES block/key and streams it out as 32-bit words,
// in column or row order, with back-to-back reload and synchronous flush.
module aes_word_streamer
  import aes_stream_pkg::*;
#(
  parameter  int SIZE    = 128,
  localparam int COL_NUM = SIZE / WORD_W,
  localparam int IDX_W   = (COL_NUM > 1) ? $clog2(COL_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_data,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last
);

  if (!(SIZE == 128 || SIZE == 192 || SIZE == 256)) begin : g_bad_size
    $error("aes_word_streamer: SIZE must be 128, 192 or 256");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COL_NUM - 1);

  stream_state_t    r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [SIZE-1:0]  r_block;
  word_mode_t       r_mode;
  word_mode_t       w_mode_in;
  logic             w_load;
  logic             w_in_hs;
  logic             w_out_hs;
  logic             w_last;

  assign out_valid = (r_state == ST_EMIT);
  assign w_last    = (r_idx == LAST_IDX);
  assign out_last  = out_valid & w_last;
  assign out_idx   = r_idx;

  // out_ready reaches in_ready combinationally so a new block can load
  // on the same edge the last word leaves, giving bubble-free streaming.
  assign in_ready  = !flush & (!out_valid | (out_last & out_ready));
  assign w_in_hs   = in_valid & in_ready;
  assign w_out_hs  = out_valid & out_ready & !flush;

  // Row order only has meaning for a 4x4 state; wider keys stay column order.
  assign w_mode_in = (COL_NUM == 4 && in_mode) ? MODE_ROW : MODE_COL;

  assign out_word  = (r_mode == MODE_ROW) ? row_word(r_block[127:0], r_idx[1:0])
                                          : r_block[WORD_W*int'(r_idx) +: WORD_W];

  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_in_hs) begin
            w_state_nxt = ST_EMIT;
            w_idx_nxt   = '0;
            w_load      = 1'b1;
          end
        end
        ST_EMIT: begin
          if (w_out_hs) begin
            if (!w_last) begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end else if (w_in_hs) begin
              w_idx_nxt = '0;
              w_load    = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
              w_idx_nxt   = '0;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // NOTE: the block register is reset because out_word must read zero out of
  // reset; flush only invalidates it and leaves the contents in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_block <= '0;
      r_mode  <= MODE_COL;
    end else if (w_load) begin
      r_block <= in_data;
      r_mode  <= w_mode_in;
    end
  end

endmodule

// File: tb/tb_aes_word_streamer.sv
// Scoreboard bench for aes_word_streamer at SIZE=128 and SIZE=256.
// Expected words come from a byte-array model of the AES state layout.
module tb_aes_word_streamer;

  typedef struct {
    logic [31:0] w;
    int          idx;
    logic        last;
  } exp_t;

  logic clk;
  logic rst_n;

  // SIZE=128 instance
  logic         flush_a, in_valid_a, in_ready_a, in_mode_a;
  logic [127:0] in_data_a;
  logic         out_valid_a, out_ready_a, out_last_a;
  logic [31:0]  out_word_a;
  logic [1:0]   out_idx_a;

  // SIZE=256 instance
  logic         flush_b, in_valid_b, in_ready_b, in_mode_b;
  logic [255:0] in_data_b;
  logic         out_valid_b, out_ready_b, out_last_b;
  logic [31:0]  out_word_b;
  logic [2:0]   out_idx_b;

  int n_cmp = 0;
  int n_err = 0;

  exp_t q128[$];
  exp_t q256[$];

  bit   rnd_ready_a = 0;
  logic fixed_ready_a = 1'b1;

  aes_word_streamer #(.SIZE(128)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a), .in_mode(in_mode_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_word(out_word_a),
    .out_idx(out_idx_a), .out_last(out_last_a)
  );

  aes_word_streamer #(.SIZE(256)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_mode(in_mode_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_word(out_word_b),
    .out_idx(out_idx_b), .out_last(out_last_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Block viewed as bytes b[0..]; column c = bytes 4c..4c+3, row r = byte r of each column.
  function automatic logic [31:0] exp_word(input logic [255:0] d, input int ncol,
                                           input logic m, input int i);
    logic [7:0] b [32];
    for (int k = 0; k < 32; k++) b[k] = d[8*k +: 8];
    if (m && ncol == 4) return {b[12+i], b[8+i], b[4+i], b[i]};
    return {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stimulus side of the scoreboard: expected words are queued on acceptance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush_a) q128.delete();
      else if (in_valid_a && in_ready_a)
        for (int i = 0; i < 4; i++)
          q128.push_back('{exp_word(256'(in_data_a), 4, in_mode_a, i), i, (i == 3)});
      if (flush_b) q256.delete();
      else if (in_valid_b && in_ready_b)
        for (int i = 0; i < 8; i++)
          q256.push_back('{exp_word(in_data_b, 8, in_mode_b, i), i, (i == 7)});
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready_a = rnd_ready_a ? logic'($urandom_range(0, 1)) : fixed_ready_a;
  end

  bit          stall_pend_a = 0;
  logic [31:0] held_word_a;
  logic [1:0]  held_idx_a;
  logic        held_last_a;

  always @(negedge rst_n) begin
    q128.delete();
    q256.delete();
    stall_pend_a = 0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (stall_pend_a) begin
        check("a_stall_valid", 32'(out_valid_a), 32'd1);
        check("a_stall_word", out_word_a, held_word_a);
        check("a_stall_idx", 32'(out_idx_a), 32'(held_idx_a));
        check("a_stall_last", 32'(out_last_a), 32'(held_last_a));
      end
      stall_pend_a = 0;
      if (out_valid_a && !flush_a) begin
        if (out_ready_a) begin
          if (q128.size() == 0) begin
            check("a_unexpected_word", out_word_a, 32'hdeadbeef);
          end else begin
            e = q128.pop_front();
            check("a_word", out_word_a, e.w);
            check("a_idx", 32'(out_idx_a), 32'(e.idx));
            check("a_last", 32'(out_last_a), 32'(e.last));
          end
        end else begin
          stall_pend_a = 1;
          held_word_a  = out_word_a;
          held_idx_a   = out_idx_a;
          held_last_a  = out_last_a;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid_b && out_ready_b && !flush_b) begin
      if (q256.size() == 0) begin
        check("b_unexpected_word", out_word_b, 32'hdeadbeef);
      end else begin
        e = q256.pop_front();
        check("b_word", out_word_b, e.w);
        check("b_idx", 32'(out_idx_b), 32'(e.idx));
        check("b_last", 32'(out_last_b), 32'(e.last));
      end
    end
  end

  task automatic send_a(input logic [127:0] d, input logic m);
    bit acc = 0;
    in_valid_a = 1'b1;
    in_data_a  = d;
    in_mode_a  = m;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk);
      #1;
    end
    in_valid_a = 1'b0;
    check("a_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send_b(input logic [255:0] d, input logic m);
    bit acc = 0;
    in_valid_b = 1'b1;
    in_data_b  = d;
    in_mode_b  = m;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready_b;
      @(posedge clk);
      #1;
    end
    in_valid_b = 1'b0;
    check("b_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain_a(input int budget);
    for (int n = 0; n < budget && q128.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check("a_drain", 32'(q128.size()), 32'd0);
  endtask

  task automatic drain_b(input int budget);
    for (int n = 0; n < budget && q256.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check("b_drain", 32'(q256.size()), 32'd0);
  endtask

  localparam logic [127:0] VEC = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [255:0] seq256;
    rst_n      = 1'b0;
    flush_a    = 1'b0; in_valid_a = 1'b0; in_mode_a = 1'b0; in_data_a = '0;
    flush_b    = 1'b0; in_valid_b = 1'b0; in_mode_b = 1'b0; in_data_b = '0;
    out_ready_b = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_out_idx", 32'(out_idx_a), 32'd0);
    check("rst_out_last", 32'(out_last_a), 32'd0);
    check("rst_out_word", out_word_a, 32'd0);
    check("rst_in_ready", 32'(in_ready_a), 32'd1);
    check("rst_b_out_valid", 32'(out_valid_b), 32'd0);
    rst_n = 1'b1;

    // Column order, then row order, of the reference vector.
    send_a(VEC, 1'b0);
    check("lat_out_valid", 32'(out_valid_a), 32'd1);
    check("lat_out_idx", 32'(out_idx_a), 32'd0);
    drain_a(20);
    send_a(VEC, 1'b1);
    check("row_first_word", out_word_a, 32'h3377bbff);
    drain_a(20);
    @(posedge clk); #1;
    check("idle_after_block", 32'(out_valid_a), 32'd0);

    // Back-to-back blocks with out_ready held high: 8 contiguous words.
    fork
      begin
        int cnt = 0;
        bit found = 0;
        for (int n = 0; n < 40 && !found; n++) begin
          @(negedge clk);
          found = out_valid_a;
        end
        while (found && out_valid_a && cnt < 20) begin
          if (cnt == 3) check("b2b_in_ready_on_last", 32'(in_ready_a), 32'd1);
          cnt++;
          @(negedge clk);
        end
        check("b2b_contiguous_words", 32'(cnt), 32'd8);
      end
      begin
        send_a(rand128(), 1'($urandom_range(0, 1)));
        send_a(rand128(), 1'($urandom_range(0, 1)));
      end
    join
    drain_a(20);

    // Random backpressure over several blocks.
    rnd_ready_a = 1;
    for (int b = 0; b < 8; b++) send_a(rand128(), 1'($urandom_range(0, 1)));
    drain_a(400);
    rnd_ready_a = 0;
    @(posedge clk); #1;

    // Flush at idx 2 with a competing input block.
    send_a(rand128(), 1'b0);
    for (int n = 0; n < 20 && out_idx_a != 2'd2; n++) begin
      @(posedge clk); #1;
    end
    check("flush_reached_idx2", 32'(out_idx_a), 32'd2);
    flush_a    = 1'b1;
    in_valid_a = 1'b1;
    in_data_a  = rand128();
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready_a), 32'd0);
    @(posedge clk); #1;
    flush_a    = 1'b0;
    in_valid_a = 1'b0;
    check("flush_out_valid", 32'(out_valid_a), 32'd0);
    check("flush_sb_empty", 32'(q128.size()), 32'd0);
    @(posedge clk); #1;
    check("flush_stays_idle", 32'(out_valid_a), 32'd0);
    send_a(rand128(), 1'b1);
    check("flush_restart_idx", 32'(out_idx_a), 32'd0);
    drain_a(20);

    // SIZE=256: row mode requested but ignored.
    for (int i = 0; i < 8; i++) seq256[32*i +: 32] = 32'(i);
    send_b(seq256, 1'b1);
    check("b_lat_out_valid", 32'(out_valid_b), 32'd1);
    check("b_first_word", out_word_b, 32'd0);
    drain_b(40);
    send_b({rand128(), rand128()}, 1'b1);
    send_b({rand128(), rand128()}, 1'b0);
    drain_b(40);

    // Asynchronous reset in the middle of a block.
    send_a(rand128(), 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid_a), 32'd0);
    check("arst_out_idx", 32'(out_idx_a), 32'd0);
    check("arst_out_last", 32'(out_last_a), 32'd0);
    check("arst_out_word", out_word_a, 32'd0);
    check("arst_in_ready", 32'(in_ready_a), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready_a), 32'd1);
    check("post_rst_out_valid", 32'(out_valid_a), 32'd0);
    @(posedge clk); #1;
    send_a(VEC, 1'b0);
    drain_a(20);

    @(posedge clk); #1;
    check("final_sb_a_empty", 32'(q128.size()), 32'd0);
    check("final_sb_b_empty", 32'(q256.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
